vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Source end of the VGA sync interface. Generates HSync/VSync with front porch, sync
//  pulse and back porch already in place, plus active-video flag and pixel coordinates.
//  Drives the video pipeline, the pixel generators and the VGA output pins.
//  Sync outputs need no further porch processing downstream.
// PARAMETERS
//  ACTIVE_COLS  640  visible pixels per line
//  ACTIVE_ROWS  480  visible lines per frame
//  TOTAL_COLS   800  clocks per line, including blanking
//  TOTAL_ROWS   525  lines per frame, including blanking
//  FRONT_HORZ   18   clocks between the last active pixel and HSync assert
//  BACK_HORZ    50   clocks between HSync deassert and end of line
//  FRONT_VERT   10   lines between the last active line and VSync assert
//  BACK_VERT    33   lines between VSync deassert and end of frame
//  SYNC_POL     0    asserted sync level (0 = active-low)
// PORTS
//  i_Clk          in   1   pixel clock, 25 MHz
//  i_Rst          in   1   synchronous reset, active-high
//  i_Enable       in   1   run timing; low = hold idle at frame origin
//  o_HSync        out  1   horizontal sync, porches included
//  o_VSync        out  1   vertical sync, porches included
//  o_Active       out  1   current position is inside ACTIVE_COLS x ACTIVE_ROWS
//  o_Col_Count    out  10  column of current position
//  o_Row_Count    out  10  row of current position
//  o_Frame_Start  out  1   one-cycle pulse at position (0,0)
//  o_Line_Start   out  1   one-cycle pulse at column 0 of every row
// BEHAVIOUR
//  - Reset and idle values:
//      o_Col_Count=0, o_Row_Count=0, o_Active=0, o_Frame_Start=0, o_Line_Start=0.
//      o_HSync and o_VSync held at ~SYNC_POL.
//  - All outputs are registered and mutually aligned: every output describes the same
//    position, which is the one shown in o_Col_Count/o_Row_Count.
//  - Startup: on the first edge with i_Rst=0 and i_Enable=1, outputs show (0,0):
//      o_Active=1, o_Frame_Start=1, o_Line_Start=1.
//  - Position sequence:
//      Each enabled clock advances the column by 1.
//      Column TOTAL_COLS-1 wraps to 0 and increments the row.
//      Row TOTAL_ROWS-1 with column TOTAL_COLS-1 wraps to (0,0).
//  - Horizontal phase FSM (state follows the column):
//      H_ACTIVE  col 0..ACTIVE_COLS-1
//      H_FRONT   next FRONT_HORZ columns
//      H_SYNC    col ACTIVE_COLS+FRONT_HORZ .. TOTAL_COLS-BACK_HORZ-1
//      H_BACK    remaining columns, then back to H_ACTIVE
//  - Vertical FSM has the same structure on rows (V_ACTIVE/V_FRONT/V_SYNC/V_BACK).
//    It advances only on column wrap.
//  - Sync levels: o_HSync = SYNC_POL only in H_SYNC; o_VSync = SYNC_POL only in V_SYNC.
//  - o_Active = 1 only when in H_ACTIVE and V_ACTIVE.
//  - Counter width: 10 bits. Parameter sets with TOTAL_* > 1024 are illegal; the
//    simulation check reports an error.
//  - i_Enable dropped mid-frame: the next edge returns all outputs to the idle values,
//    with no partial sync pulse held.
//    Re-enabling restarts at (0,0) with an o_Frame_Start pulse.
//  - i_Rst takes priority over i_Enable. Reset asserted mid-frame gives the idle values
//    on the next edge.
// CONFIGURATION
//  VGA_FRAME_COUNT_EN defined:
//    Adds port o_Frame_Count (out, 8 bits).
//    Resets to 0 and increments in the same cycle o_Frame_Start pulses, so it reads 1
//    during the first frame. 255 wraps to 0.
//    Unchanged while idle or disabled.
//  VGA_FRAME_COUNT_EN undefined: the port and its counter are absent; all other
//    behaviour is identical.
// TESTING
//  1 Reset 5 clocks, then enable -> first edge shows col=0, row=0, Active=1,
//    Frame_Start=1, HSync=1, VSync=1.
//  2 Free run, default params -> HSync=0 exactly for cols 658..749, 92 clocks;
//    Active=1 for cols 0..639 only.
//  3 Free run -> VSync=0 exactly for rows 490..491;
//    Frame_Start period is 420000 clocks; Line_Start period is 800 clocks.
//  4 Drop i_Enable at col 700, row 100 -> next edge gives all idle values.
//    Re-enable -> col=0, row=0, Frame_Start=1.
//  5 Assert i_Rst at col 660 (inside HSync) -> next edge HSync=1, counts 0,
//    Active=0, with no glitch.
//  6 VGA_FRAME_COUNT_EN defined, run 257 frames -> o_Frame_Count goes 1,2,...,255,0,1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Source end of the VGA sync interface. Walks a pixel position across
//   TOTAL_COLS x TOTAL_ROWS and produces HSync/VSync with porches already in
//   place, an active-video flag, the pixel coordinates and line/frame start
//   pulses. Every output is registered and describes the same position.
//
//   Optional feature macro: VGA_FRAME_COUNT_EN adds an 8-bit frame counter.
//
// Ports
//   i_Clk          in   pixel clock
//   i_Rst          in   synchronous reset, active-high (priority over enable)
//   i_Enable       in   run timing; low holds idle at the frame origin
//   o_HSync        out  horizontal sync (SYNC_POL while asserted)
//   o_VSync        out  vertical sync (SYNC_POL while asserted)
//   o_Active       out  position lies inside the visible area
//   o_Col_Count    out  column of the current position
//   o_Row_Count    out  row of the current position
//   o_Frame_Start  out  one-cycle pulse at (0,0)
//   o_Line_Start   out  one-cycle pulse at column 0 of every row
//   o_Frame_Count  out  frame counter (VGA_FRAME_COUNT_EN only)
//
// Phase FSMs
//   state    | meaning
//   ---------+-------------------------------------------------
//   H_ACTIVE | visible columns 0..ACTIVE_COLS-1
//   H_FRONT  | horizontal front porch
//   H_SYNC   | horizontal sync pulse
//   H_BACK   | horizontal back porch, up to end of line
//   V_ACTIVE | visible rows 0..ACTIVE_ROWS-1
//   V_FRONT  | vertical front porch
//   V_SYNC   | vertical sync pulse
//   V_BACK   | vertical back porch, up to end of frame
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int   ACTIVE_COLS = 640,
  parameter int   ACTIVE_ROWS = 480,
  parameter int   TOTAL_COLS  = 800,
  parameter int   TOTAL_ROWS  = 525,
  parameter int   FRONT_HORZ  = 18,
  parameter int   BACK_HORZ   = 50,
  parameter int   FRONT_VERT  = 10,
  parameter int   BACK_VERT   = 33,
  parameter logic SYNC_POL    = 1'b0
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Enable,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_Active,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Frame_Start,
  output logic       o_Line_Start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] o_Frame_Count
`endif
);

  if (TOTAL_COLS > 1024 || TOTAL_ROWS > 1024) begin : g_bad_params
    $error("vga_timing_gen: TOTAL_COLS/TOTAL_ROWS exceed the 10-bit counters");
  end

  // Last column/row of each phase; a phase ends when the position reaches it.
  localparam logic [9:0] COL_LAST   = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST   = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] H_ACT_END  = 10'(ACTIVE_COLS - 1);
  localparam logic [9:0] H_FP_END   = 10'(ACTIVE_COLS + FRONT_HORZ - 1);
  localparam logic [9:0] H_SYNC_END = 10'(TOTAL_COLS - BACK_HORZ - 1);
  localparam logic [9:0] V_ACT_END  = 10'(ACTIVE_ROWS - 1);
  localparam logic [9:0] V_FP_END   = 10'(ACTIVE_ROWS + FRONT_VERT - 1);
  localparam logic [9:0] V_SYNC_END = 10'(TOTAL_ROWS - BACK_VERT - 1);

  typedef enum logic [1:0] {H_ACTIVE, H_FRONT, H_SYNC, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACTIVE, V_FRONT, V_SYNC, V_BACK} v_state_t;

  h_state_t   h_state, h_nxt;
  v_state_t   v_state, v_nxt;
  logic       running;
  logic [9:0] col_nxt, row_nxt;
  logic       col_wrap;

  assign col_wrap = (o_Col_Count == COL_LAST);

  // Position and phase the next enabled edge will show. From idle the next
  // position is always the frame origin.
  always_comb begin
    col_nxt = '0;
    row_nxt = '0;
    h_nxt   = H_ACTIVE;
    v_nxt   = V_ACTIVE;
    if (running) begin
      if (col_wrap) begin
        col_nxt = '0;
        row_nxt = (o_Row_Count == ROW_LAST) ? 10'd0 : o_Row_Count + 10'd1;
      end else begin
        col_nxt = o_Col_Count + 10'd1;
        row_nxt = o_Row_Count;
      end

      h_nxt = h_state;
      case (h_state)
        H_ACTIVE: if (o_Col_Count == H_ACT_END)  h_nxt = H_FRONT;
        H_FRONT:  if (o_Col_Count == H_FP_END)   h_nxt = H_SYNC;
        H_SYNC:   if (o_Col_Count == H_SYNC_END) h_nxt = H_BACK;
        H_BACK:   if (col_wrap)                  h_nxt = H_ACTIVE;
        default:                                 h_nxt = H_ACTIVE;
      endcase

      v_nxt = v_state;
      if (col_wrap) begin
        case (v_state)
          V_ACTIVE: if (o_Row_Count == V_ACT_END)  v_nxt = V_FRONT;
          V_FRONT:  if (o_Row_Count == V_FP_END)   v_nxt = V_SYNC;
          V_SYNC:   if (o_Row_Count == V_SYNC_END) v_nxt = V_BACK;
          V_BACK:   if (o_Row_Count == ROW_LAST)   v_nxt = V_ACTIVE;
          default:                                 v_nxt = V_ACTIVE;
        endcase
      end
    end
  end

  // Outputs are decoded from the next state so they line up with the
  // registered position rather than trailing it by a clock.
  always_ff @(posedge i_Clk) begin
    if (i_Rst || !i_Enable) begin
      running       <= 1'b0;
      h_state       <= H_ACTIVE;
      v_state       <= V_ACTIVE;
      o_Col_Count   <= '0;
      o_Row_Count   <= '0;
      o_HSync       <= ~SYNC_POL;
      o_VSync       <= ~SYNC_POL;
      o_Active      <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Line_Start  <= 1'b0;
    end else begin
      running       <= 1'b1;
      h_state       <= h_nxt;
      v_state       <= v_nxt;
      o_Col_Count   <= col_nxt;
      o_Row_Count   <= row_nxt;
      o_HSync       <= (h_nxt == H_SYNC) ? SYNC_POL : ~SYNC_POL;
      o_VSync       <= (v_nxt == V_SYNC) ? SYNC_POL : ~SYNC_POL;
      o_Active      <= (h_nxt == H_ACTIVE) && (v_nxt == V_ACTIVE);
      o_Frame_Start <= (col_nxt == 10'd0) && (row_nxt == 10'd0);
      o_Line_Start  <= (col_nxt == 10'd0);
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  // Counts with the Frame_Start pulse, so the first frame reads 1; holds
  // while disabled and wraps naturally at 8 bits.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Frame_Count <= '0;
    end else if (i_Enable && col_nxt == 10'd0 && row_nxt == 10'd0) begin
      o_Frame_Count <= o_Frame_Count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Horizontal timing uses the default
// 640/800 line; the frame is shortened to 14 rows (6 visible, sync rows
// 8..10) so whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int AC = 640, TC = 800, FH = 18, BH = 50;
  localparam int AR = 6, TR = 14, FV = 2, BV = 3;
  localparam int FRAME = TC * TR;

  logic       clk = 1'b0;
  logic       rst, en;
  logic       hs, vs, act, fs, ls;
  logic [9:0] col, row;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] fc;
`endif

  int total = 0;
  int bad   = 0;

  always #20 clk = ~clk;

  vga_timing_gen #(
    .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
    .FRONT_HORZ(FH), .BACK_HORZ(BH), .FRONT_VERT(FV), .BACK_VERT(BV),
    .SYNC_POL(1'b0)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en),
    .o_HSync(hs), .o_VSync(vs), .o_Active(act),
    .o_Col_Count(col), .o_Row_Count(row),
    .o_Frame_Start(fs), .o_Line_Start(ls)
`ifdef VGA_FRAME_COUNT_EN
    , .o_Frame_Count(fc)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    repeat (5) step();
    total++; if ({col, row} !== 20'd0) begin bad++; $display("FAIL reset_pos got col=%0d row=%0d want 0,0", col, row); end
    total++; if ({act, fs, ls} !== 3'b000) begin bad++; $display("FAIL reset_flags got act/fs/ls=%b want 000", {act, fs, ls}); end
    total++; if ({hs, vs} !== 2'b11) begin bad++; $display("FAIL reset_sync got hs/vs=%b want 11", {hs, vs}); end
    // Reset wins over enable.
    en = 1'b1;
    step();
    total++; if ({act, fs, hs, vs, col} !== {4'b0011, 10'd0}) begin bad++; $display("FAIL reset_priority got act=%b fs=%b col=%0d", act, fs, col); end
  endtask

  task automatic test_startup();
    rst = 1'b0; en = 1'b1;
    step();
    total++; if ({col, row} !== 20'd0) begin bad++; $display("FAIL start_pos got col=%0d row=%0d want 0,0", col, row); end
    total++; if ({act, fs, ls, hs, vs} !== 5'b11111) begin bad++; $display("FAIL start_flags got act/fs/ls/hs/vs=%b want 11111", {act, fs, ls, hs, vs}); end
  endtask

  // Walk the rest of line 0 column by column.
  task automatic test_hsync_line();
    int low = 0;
    for (int c = 1; c < TC; c++) begin
      step();
      if (hs === 1'b0) low++;
      total++; if (col !== 10'(c) || row !== 10'd0) begin bad++; $display("FAIL line_pos got col=%0d row=%0d want %0d,0", col, row, c); end
      total++; if (hs !== !(c >= 658 && c <= 749)) begin bad++; $display("FAIL hsync col=%0d got %b", c, hs); end
      total++; if (act !== (c < 640)) begin bad++; $display("FAIL active col=%0d got %b", c, act); end
      total++; if ((fs | ls) !== 1'b0) begin bad++; $display("FAIL pulse_mid col=%0d got fs=%b ls=%b want 0", c, fs, ls); end
    end
    total++; if (low != 92) begin bad++; $display("FAIL hsync_width got %0d want 92", low); end
    step();
    total++; if ({col, row, ls, fs} !== {10'd0, 10'd1, 2'b10}) begin bad++; $display("FAIL line_wrap got col=%0d row=%0d ls=%b fs=%b want 0,1,1,0", col, row, ls, fs); end
  endtask

  // Two full frames against a position model, measuring pulse periods.
  task automatic test_frame_run();
    int ec = 0, er = 1;
    int last_fs = -1, last_ls = 0, vlow = 0;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      ec++;
      if (ec == TC) begin ec = 0; er = (er == TR - 1) ? 0 : er + 1; end
      step();
      total++; if (col !== 10'(ec) || row !== 10'(er)) begin bad++; $display("FAIL frame_pos got col=%0d row=%0d want %0d,%0d", col, row, ec, er); end
      total++; if (vs !== !(er >= 8 && er <= 10)) begin bad++; $display("FAIL vsync row=%0d col=%0d got %b", er, ec, vs); end
      total++; if (hs !== !(ec >= 658 && ec <= 749)) begin bad++; $display("FAIL hsync_frame row=%0d col=%0d got %b", er, ec, hs); end
      total++; if (act !== (ec < AC && er < AR)) begin bad++; $display("FAIL active_frame row=%0d col=%0d got %b", er, ec, act); end
      total++; if (fs !== (ec == 0 && er == 0)) begin bad++; $display("FAIL frame_start row=%0d col=%0d got %b", er, ec, fs); end
      if (vs === 1'b0 && ec == 0) vlow++;
      if (fs === 1'b1) begin
        if (last_fs >= 0) begin
          total++; if (i - last_fs != FRAME) begin bad++; $display("FAIL fs_period got %0d want %0d", i - last_fs, FRAME); end
        end
        last_fs = i;
      end
      if (ls === 1'b1) begin
        total++; if (i - last_ls != TC) begin bad++; $display("FAIL ls_period got %0d want %0d", i - last_ls, TC); end
        last_ls = i;
      end
    end
    total++; if (vlow != 6) begin bad++; $display("FAIL vsync_lines got %0d want 6 over two frames", vlow); end
  endtask

  task automatic test_enable_drop();
    int n = 0;
    while (!(col == 10'd700 && row == 10'd5) && n < 2 * FRAME) begin step(); n++; end
    total++; if (n >= 2 * FRAME) begin bad++; $display("FAIL drop_wait timeout got col=%0d row=%0d", col, row); end
    total++; if (hs !== 1'b0) begin bad++; $display("FAIL drop_insync got hs=%b want 0", hs); end
    en = 1'b0;
    step();
    total++; if ({col, row} !== 20'd0) begin bad++; $display("FAIL drop_pos got col=%0d row=%0d want 0,0", col, row); end
    total++; if ({act, fs, ls, hs, vs} !== 5'b00011) begin bad++; $display("FAIL drop_flags got act/fs/ls/hs/vs=%b want 00011", {act, fs, ls, hs, vs}); end
    step();
    total++; if ({col, act, fs} !== {10'd0, 2'b00}) begin bad++; $display("FAIL drop_hold got col=%0d act=%b fs=%b", col, act, fs); end
    en = 1'b1;
    step();
    total++; if ({col, row, fs, act, ls} !== {20'd0, 3'b111}) begin bad++; $display("FAIL reenable got col=%0d row=%0d fs=%b act=%b ls=%b", col, row, fs, act, ls); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (col != 10'd660 && n < 2 * TC) begin step(); n++; end
    total++; if (n >= 2 * TC) begin bad++; $display("FAIL rstmid_wait timeout got col=%0d", col); end
    total++; if (hs !== 1'b0) begin bad++; $display("FAIL rstmid_insync got hs=%b want 0", hs); end
    rst = 1'b1;
    step();
    total++; if ({hs, vs, act, fs, ls} !== 5'b11000) begin bad++; $display("FAIL rstmid_flags got hs/vs/act/fs/ls=%b want 11000", {hs, vs, act, fs, ls}); end
    total++; if ({col, row} !== 20'd0) begin bad++; $display("FAIL rstmid_pos got col=%0d row=%0d want 0,0", col, row); end
    rst = 1'b0;
    step();
    total++; if ({col, row, fs, hs} !== {20'd0, 2'b11}) begin bad++; $display("FAIL rstmid_restart got col=%0d row=%0d fs=%b hs=%b", col, row, fs, hs); end
  endtask

`ifdef VGA_FRAME_COUNT_EN
  task automatic test_frame_count();
    rst = 1'b1; en = 1'b1;
    step();
    total++; if (fc !== 8'd0) begin bad++; $display("FAIL fc_reset got %0d want 0", fc); end
    rst = 1'b0;
    step();
    total++; if (fc !== 8'd1) begin bad++; $display("FAIL fc_first got %0d want 1", fc); end
    for (int f = 2; f <= 3; f++) begin
      repeat (FRAME) step();
      total++; if (fc !== 8'(f) || fs !== 1'b1) begin bad++; $display("FAIL fc_frame got %0d fs=%b want %0d", fc, fs, f); end
    end
    en = 1'b0;
    repeat (3) step();
    total++; if (fc !== 8'd3) begin bad++; $display("FAIL fc_hold got %0d want 3", fc); end
    en = 1'b1;
    step();
    total++; if (fc !== 8'd4) begin bad++; $display("FAIL fc_restart got %0d want 4", fc); end
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0;
    test_reset();
    test_startup();
    test_hsync_line();
    test_frame_run();
    test_enable_drop();
    test_reset_mid();
`ifdef VGA_FRAME_COUNT_EN
    test_frame_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
